// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the memory-mapped serial transmitter.
package cpu_io_pkg;

  // Transmitter line states: idle, then start bit, eight data bits, stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Default bus addresses of the transmit and status registers.
  localparam logic [31:0] TX_ADDR_DEF     = 32'h0000_0100;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0104;

  // Bit positions inside the status word.
  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with first-word fall-through output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Byte storage write port.
  // NOTE: storage is deliberately not reset; empty pointers make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter sitting beside data memory.
// Stores to TX_ADDR queue a byte; STATUS_ADDR exposes overflow/full/empty/busy
// and a store there with bit 3 set clears the sticky overflow flag.
module mmio_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TX_ADDR      = WIDTH'(TX_ADDR_DEF),
  parameter logic [WIDTH-1:0] STATUS_ADDR  = WIDTH'(STATUS_ADDR_DEF),
  parameter int               CLKS_PER_BIT = 16,
  parameter int               FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  output logic [WIDTH-1:0] rdata,
  output logic             tx,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             ovf_q, ovf_d;

  logic             push_req;
  logic             clr_req;
  logic             pop_req;
  logic             cnt_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             unused_wdata;

  assign push_req     = we && (addr == TX_ADDR);
  assign clr_req      = we && (addr == STATUS_ADDR) && wdata[3];
  assign cnt_last     = (cnt_q == CNT_LAST);
  assign unused_wdata = ^wdata[WIDTH-1:8];

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req),
    .din  (wdata[7:0]),
    .pop  (pop_req),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sticky overflow: a dropped push sets it, a status store with bit 3 clears it; set wins.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ovf_d = ovf_q;
    if (clr_req) ovf_d = 1'b0;
    if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  // Transmitter state register with baud counter, bit index and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic; frames chain straight from STOP into START when bytes are waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          sh_d    = fifo_dout;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop_req = 1'b1;
            sh_d    = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy outputs decoded from registered state only.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      default: tx = 1'b1;
    endcase
    busy = (state_q != IDLE) || !fifo_empty;
  end

  // Status readback, zero at every address other than STATUS_ADDR.
  always_comb begin
    rdata = '0;
    if (addr == STATUS_ADDR) begin
      rdata[ST_BUSY]  = busy;
      rdata[ST_EMPTY] = fifo_empty;
      rdata[ST_FULL]  = fifo_full;
      rdata[ST_OVF]   = ovf_q;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a cycle-level reference model predicts
// which bytes are accepted and when frames start; a line monitor decodes frames
// from tx and compares them against the expected-byte queue.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] TXA   = 32'h0000_0100;
  localparam logic [31:0] STA   = 32'h0000_0104;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf     = 1'b0;
  int         cyc       = 0;
  int         next_free = 0;
  bit         pop_now;

  // Monitor state.
  logic [FRAME-1:0] smp;
  int               mon_k      = 0;
  bit               mon_active = 1'b0;
  int               n_frames   = 0;
  logic [7:0]       got;
  bit               shape_ok;
  logic [7:0]       exp_b;

  int last_store_cyc;

  mmio_uart_tx #(
    .WIDTH       (32),
    .TX_ADDR     (TXA),
    .STATUS_ADDR (STA),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .rdata(rdata),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s    = '0;
    s[3] = m_ovf;
    s[2] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[0] = (mq.size() != 0) || (cyc < next_free);
    return s;
  endfunction

  // Reference model: the transmitter takes the next queued byte as soon as it is
  // free (one cycle after arrival when idle, right at the end of a frame otherwise);
  // each frame occupies the line for FRAME cycles.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        exp_q.delete();
        m_ovf     = 1'b0;
        next_free = 0;
      end else begin
        cyc++;
        pop_now = (mq.size() != 0) && (cyc >= next_free);
        if (pop_now) begin
          exp_q.push_back(mq.pop_front());
          next_free = cyc + FRAME;
        end
        if (we && addr == TXA) begin
          if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
          else                   m_ovf = 1'b1;
        end else if (we && addr == STA && wdata[3]) begin
          m_ovf = 1'b0;
        end
      end
    end
  end

  // Line monitor: capture FRAME samples from each falling start edge, check the
  // 8N1 shape and compare the LSB-first byte against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 1'b0;
        mon_k      = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          smp[0]     = 1'b0;
          mon_k      = 1;
        end
      end else begin
        smp[mon_k] = tx;
        mon_k++;
        if (mon_k == FRAME) begin
          mon_active = 1'b0;
          n_frames++;
          shape_ok = 1'b1;
          for (int j = 0; j < CPB; j++) begin
            if (smp[j] !== 1'b0) shape_ok = 1'b0;
            if (smp[9*CPB+j] !== 1'b1) shape_ok = 1'b0;
          end
          for (int b = 0; b < 8; b++) begin
            got[b] = smp[(b+1)*CPB];
            for (int j = 0; j < CPB; j++)
              if (smp[(b+1)*CPB+j] !== got[b]) shape_ok = 1'b0;
          end
          check("frame_shape", {31'b0, shape_ok}, 32'h1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL frame_unexpected: got byte 0x%0h with nothing expected (cycle %0d)", got, cyc);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_byte", {24'b0, got}, {24'b0, exp_b});
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    last_store_cyc = cyc;
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      we    = 1'b0;
      addr  = 32'h1000_0000 | $urandom;
      wdata = $urandom;
    end
  endtask

  task automatic read_model(input string name);
    @(negedge clk);
    we   = 1'b0;
    addr = STA;
    #1;
    check(name, rdata, model_status());
  endtask

  task automatic read_const(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    we   = 1'b0;
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wait_tx_low(input string name, output int at);
    int n;
    n  = 0;
    at = -1;
    while (at < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) at = cyc;
    end
    if (at < 0) check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic wait_busy_low(input string name, input int limit, output int at);
    int n;
    n  = 0;
    at = -1;
    while (at < 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) at = cyc;
    end
    if (at < 0) check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic watch_idle(input string name, input int n);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check(name, {31'b0, ok}, 32'h1);
  endtask

  // Reset during data bit 3 must force tx high at once and discard everything.
  task automatic reset_mid_frame(input string tag, input logic [7:0] b);
    int s;
    bus_write(TXA, {24'h0, b});
    s = last_store_cyc;
    bus_idle(1);
    while (cyc < s + 18) @(negedge clk);
    check({tag, "_bit3_on_line"}, {31'b0, tx}, {31'b0, b[3]});
    #2 reset = 1'b0;
    #1;
    check({tag, "_async_tx"}, {31'b0, tx}, 32'h1);
    check({tag, "_async_busy"}, {31'b0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    read_const({tag, "_status_after"}, STA, 32'h2);
    watch_idle({tag, "_no_resume"}, 60);
  endtask

  initial begin
    int s, fall, bfall, f0;
    int unsigned r;
    bit done;

    // 1: reset and quiet line.
    repeat (3) @(negedge clk);
    check("t1_rst_tx", {31'b0, tx}, 32'h1);
    check("t1_rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b1;
    bus_idle(20);
    check("t1_idle_tx", {31'b0, tx}, 32'h1);
    check("t1_idle_busy", {31'b0, busy}, 32'h0);
    read_const("t1_status", STA, 32'h2);

    // 2: single byte timing.
    bus_write(TXA, 32'h0000_00A5);
    s = last_store_cyc;
    bus_idle(1);
    wait_tx_low("t2_tx_fall", fall);
    check("t2_start_latency", fall - s, 32'd1);
    wait_busy_low("t2_busy_fall", 200, bfall);
    check("t2_frame_len", bfall - fall, FRAME);

    // 3: five back-to-back bytes, contiguous frames, no overflow.
    bus_write(TXA, 32'h11);
    s = last_store_cyc;
    bus_write(TXA, 32'h22);
    bus_write(TXA, 32'h33);
    bus_write(TXA, 32'h44);
    bus_write(TXA, 32'h55);
    read_model("t3_status_model");
    check("t3_no_ovf", {31'b0, rdata[3]}, 32'h0);
    wait_busy_low("t3_busy_fall", 400, bfall);
    check("t3_total_len", bfall - s, 5 * FRAME + 1);

    // 4: six back-to-back bytes, sixth dropped, then overflow clear.
    bus_write(TXA, 32'h61);
    bus_write(TXA, 32'h62);
    bus_write(TXA, 32'h63);
    bus_write(TXA, 32'h64);
    bus_write(TXA, 32'h65);
    bus_write(TXA, 32'h66);
    read_model("t4_status_model");
    check("t4_ovf_set", {31'b0, rdata[3]}, 32'h1);
    bus_write(STA, 32'h8);
    read_model("t4_status_cleared");
    check("t4_ovf_clear", {31'b0, rdata[3]}, 32'h0);
    wait_busy_low("t4_busy_fall", 400, bfall);

    // 5: asynchronous reset mid-frame.
    reset_mid_frame("t5a", 8'hFF);
    reset_mid_frame("t5b", 8'h00);

    // 6: stores to other addresses do nothing.
    f0 = n_frames;
    bus_write(32'h108, 32'h5A);
    bus_write(32'h0FF, 32'h5A);
    bus_idle(1);
    watch_idle("t6_no_tx", 50);
    check("t6_no_frames", n_frames - f0, 32'h0);
    read_const("t6_status", STA, 32'h2);
    read_const("t6_rdata_108", 32'h108, 32'h0);
    read_const("t6_rdata_100", TXA, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      bus_write(TXA, $urandom);
      else if (r < 55) bus_write(STA, $urandom);
      else if (r < 65) bus_write(32'h1000_0000 | $urandom, $urandom);
      else if (r < 90) read_model("rnd_status");
      else             read_const("rnd_other_rdata", 32'h1000_0000 | $urandom, 32'h0);
      bus_idle($urandom_range(0, 12));
    end
    bus_idle(1);

    // Drain and final accounting.
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0 && !mon_active) done = 1'b1;
    end
    check("drain_done", {31'b0, done}, 32'h1);
    read_model("drain_status");
    check("drain_exp_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped serial transmitter on the CPU data-memory bus, beside the data memory. It decodes the same address, store-data and write-enable signals that the datapath drives to data memory. Stores to TX_ADDR queue one byte in a small FIFO, and the block serialises queued bytes as 8N1 frames on tx. A status word is readable at STATUS_ADDR, so programs can poll before storing.

Parameters:
WIDTH, 32, bus width of addr/wdata/rdata
TX_ADDR, 32'h0000_0100, store here pushes wdata[7:0] into the FIFO
STATUS_ADDR, 32'h0000_0104, status read / overflow-clear address
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
addr  input  WIDTH  bus address (datapath ALU result)
wdata  input  WIDTH  store data from datapath
we  input  1  store strobe (same as data-memory write enable)
rdata  output  WIDTH  status readback, combinational
tx  output  1  serial line, idle high
busy  output  1  1 while a frame is on the line or the FIFO is non-empty

Behaviour:
- Reset (reset=0, async): FIFO empty, overflow=0, FSM=IDLE, tx=1, busy=0, baud counter=0, bit index=0. Reset asserted mid-frame forces tx=1 immediately and discards the frame in progress and all queued bytes.
- Push: on a rising clk with we=1 and addr==TX_ADDR.
  - If the FIFO is not full, or a pop occurs on the same edge, wdata[7:0] is written at the tail.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - wdata[WIDTH-1:8] is ignored.
- Overflow clear: we=1, addr==STATUS_ADDR, wdata[3]=1 clears overflow. If a dropped push and a clear occur on the same edge, set wins. A push and a clear cannot coincide, because the addresses differ.
- rdata: when addr==STATUS_ADDR, rdata = {zeros, overflow[3], full[2], empty[1], busy[0]}; otherwise rdata=0.
- FSM states: IDLE, START, DATA, STOP. Baud counter cnt runs 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. When the FIFO is non-empty, pop the head into shift register sh, set cnt=0, go to START. tx drops on the edge after the push edge, so latency is 1 cycle from an empty FIFO.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=sh[0], sent LSB first. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift sh right and increment the index. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START, with no idle cycle between frames.
    - FIFO empty: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- busy = (state!=IDLE) | !empty, registered-state derived, no extra latency.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full = MSBs differ and the low bits are equal. Count never exceeds FIFO_DEPTH.
- A store to any other address has no effect. Stores to TX_ADDR are not blocked by busy.

Decomposition:
- Package cpu_io_pkg holds:
  - typedef enum logic [1:0] uart_state_t {IDLE, START, DATA, STOP}
  - constants TX_ADDR_DEF and STATUS_ADDR_DEF
  - status bit indices ST_BUSY=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3
- One sub-module, byte_fifo: a synchronous FIFO with parameter DEPTH and ports clk, reset, push, din[7:0], pop, dout[7:0], full, empty. It is instantiated once.
- The FSM, baud counter and address decode live in mmio_uart_tx.

Test Plan (all scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset is released; no stores for 20 cycles -> tx=1, busy=0, and a read of 0x104 gives rdata=32'h2 (empty).
2. Store 0x0000_00A5 to 0x100 -> tx is low for cycles 1-4 after the store edge. Data bits follow LSB first as 1,0,1,0,0,1,0,1, 4 cycles each. Then stop=1. busy falls exactly 40 cycles after tx fell.
3. Five back-to-back stores (0x11,0x22,0x33,0x44,0x55) -> 0x11 pops at once, so all five fit without overflow. Frames are contiguous: each start bit follows the previous stop bit with no idle cycle, 200 cycles total. overflow stays 0.
4. Six back-to-back stores while idle -> the sixth byte is dropped and a status read returns bit3=1. Storing 32'h8 to 0x104 clears overflow to 0, and the transmitted bytes are the first five only.
5. Store 0xFF, then assert reset low during data bit 3 -> tx=1 in the same cycle, asynchronously. After release: busy=0, status=32'h2, and no frame resumes.
6. Stores to 0x108 and 0x0FF with wdata=0x5A -> no tx activity, FIFO stays empty, and rdata=0 when addr≠0x104.
